// File: rtl/xvk_fifo.sv
// xvk_fifo: single-clock first-word-fall-through FIFO.
// The head entry is kept in a registered output stage, so dout is valid
// whenever empty is low. The storage array can be read synchronously,
// which suits block RAM. Flags are decoded from the registered occupancy count.
module xvk_fifo #(
    parameter int    WIDTH     = 8,
    parameter int    DEPTH     = 16,
    parameter int    PROG_FULL = DEPTH / 2,
    parameter string RAM_TYPE  = "BLOCK"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic             last,
    output logic             prog_full,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PFULL_C = CW'(PROG_FULL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PINC_C  = AW'(1);

    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rd_word;
    logic             wr_acc, rd_acc;
    logic             bypass;

    // Flags come from registered state only.
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign last      = (count_q == ONE_C);
    assign prog_full = (count_q >= PFULL_C);
    assign dout      = dout_q;

    // Storage array. The read address is the post-update head pointer, so
    // the word lands in the output register on the same edge the pointer moves.
    generate
        if (RAM_TYPE == "DISTRIBUTED") begin : g_dist
            (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
            // Write port.
            always_ff @(posedge clk) begin
                if (wr_acc) mem[wp_q] <= din;
            end
            assign rd_word = mem[rp_d];
        end else if (RAM_TYPE == "REGISTER") begin : g_reg
            (* ram_style = "registers" *) logic [WIDTH-1:0] mem [DEPTH];
            // Write port.
            always_ff @(posedge clk) begin
                if (wr_acc) mem[wp_q] <= din;
            end
            assign rd_word = mem[rp_d];
        end else begin : g_block
            (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
            // Write port.
            always_ff @(posedge clk) begin
                if (wr_acc) mem[wp_q] <= din;
            end
            assign rd_word = mem[rp_d];
        end
    endgenerate

    // Next-state for pointers, count and the head (output) register.
    always_comb begin
        wr_acc  = wr_en && !full;
        rd_acc  = rd_en && !empty;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (wr_acc) wp_d = wp_q + PINC_C;
        if (rd_acc) rp_d = rp_q + PINC_C;
        if (wr_acc && !rd_acc) count_d = count_q + ONE_C;
        if (rd_acc && !wr_acc) count_d = count_q - ONE_C;
        // The incoming word becomes the head when nothing else remains:
        // writing into an empty FIFO, or replacing the sole entry.
        bypass = wr_acc && (empty || (last && rd_acc));
        if (bypass) begin
            dout_d = din;
        end else if (count_d != '0) begin
            dout_d = rd_word;
        end
    end

    // State registers; reset clears control state and the visible head.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_xvk_fifo.sv
// tb_xvk_fifo: directed bench for xvk_fifo (DEPTH=4, WIDTH=8, PROG_FULL=2)
// with a queue scoreboard of expected FIFO contents.
module tb_xvk_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int PF = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] din;
    logic         full;
    logic         empty;
    logic         last;
    logic         prog_full;
    logic [W-1:0] dout;

    logic [W-1:0] sb[$];
    int           ncmp  = 0;
    int           nfail = 0;

    xvk_fifo #(
        .WIDTH    (W),
        .DEPTH    (D),
        .PROG_FULL(PF),
        .RAM_TYPE ("BLOCK")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .din      (din),
        .full     (full),
        .empty    (empty),
        .last     (last),
        .prog_full(prog_full),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all flags, and the head while non-empty, against the scoreboard.
    task automatic chk_model(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == D));
        chk({tag, ".last"}, 32'(last), 32'(n == 1));
        chk({tag, ".pfull"}, 32'(prog_full), 32'(n >= PF));
        if (n > 0) chk({tag, ".dout"}, 32'(dout), 32'(sb[0]));
    endtask

    // One clock: drive inputs, take the edge, update the model, sample 1ns later.
    task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d,
                        input string tag);
        bit wacc, racc;
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        wacc = w && (sb.size() != D);
        racc = rd && (sb.size() != 0);
        if (r) begin
            sb.delete();
        end else begin
            if (racc) void'(sb.pop_front());
            if (wacc) sb.push_back(d);
        end
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_model(tag);
    endtask

    initial begin
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        // T1 reset
        step(1'b1, 1'b0, 1'b0, 8'h00, "t1_rst0");
        step(1'b1, 1'b0, 1'b0, 8'h00, "t1_rst1");
        chk("t1_dout0", 32'(dout), 32'h00);
        chk("t1_empty", 32'(empty), 32'd1);

        // T2 fill
        step(1'b0, 1'b1, 1'b0, 8'h11, "t2_w11");
        chk("t2_first_dout", 32'(dout), 32'h11);
        chk("t2_first_last", 32'(last), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h22, "t2_w22");
        chk("t2_pfull", 32'(prog_full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h33, "t2_w33");
        step(1'b0, 1'b1, 1'b0, 8'h44, "t2_w44");
        chk("t2_full", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h55, "t2_w55_drop");
        chk("t2_drop_dout", 32'(dout), 32'h11);

        // T3 drain
        step(1'b0, 1'b0, 1'b1, 8'h00, "t3_r1");
        chk("t3_dout22", 32'(dout), 32'h22);
        step(1'b0, 1'b0, 1'b1, 8'h00, "t3_r2");
        chk("t3_dout33", 32'(dout), 32'h33);
        step(1'b0, 1'b0, 1'b1, 8'h00, "t3_r3");
        chk("t3_dout44", 32'(dout), 32'h44);
        chk("t3_last44", 32'(last), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00, "t3_r4");
        chk("t3_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00, "t3_r_empty");
        chk("t3_hold", 32'(dout), 32'h44);

        // T4 simultaneous read/write with two entries; pointers wrap twice
        step(1'b0, 1'b1, 1'b0, 8'hB0, "t4_pre0");
        step(1'b0, 1'b1, 1'b0, 8'hB1, "t4_pre1");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'hA0 + i), $sformatf("t4_rw%0d", i));
            chk($sformatf("t4_cnt2_%0d", i), 32'(prog_full && !full && !last && !empty), 32'd1);
        end
        chk("t4_head", 32'(dout), 32'hA6);
        step(1'b0, 1'b0, 1'b1, 8'h00, "t4_drain0");
        chk("t4_tail", 32'(dout), 32'hA7);
        step(1'b0, 1'b0, 1'b1, 8'h00, "t4_drain1");

        // T5 edges: read+write when empty, then when full
        step(1'b0, 1'b1, 1'b1, 8'hC5, "t5_rw_empty");
        chk("t5_bypass", 32'(dout), 32'hC5);
        step(1'b0, 1'b1, 1'b0, 8'hC6, "t5_f1");
        step(1'b0, 1'b1, 1'b0, 8'hC7, "t5_f2");
        step(1'b0, 1'b1, 1'b0, 8'hC8, "t5_f3");
        chk("t5_full", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b1, 8'hEE, "t5_rw_full");
        chk("t5_notfull", 32'(full), 32'd0);
        chk("t5_head", 32'(dout), 32'hC6);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00, $sformatf("t5_drain%0d", i));
        chk("t5_end_empty", 32'(empty), 32'd1);

        // Sole-entry replace: count 1, read+write -> new word is head
        step(1'b0, 1'b1, 1'b0, 8'h5A, "t5_one");
        step(1'b0, 1'b1, 1'b1, 8'hA5, "t5_replace");
        chk("t5_replace_dout", 32'(dout), 32'hA5);
        chk("t5_replace_last", 32'(last), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00, "t5_replace_drain");

        // T6 reset mid-stream
        step(1'b0, 1'b1, 1'b0, 8'h61, "t6_w0");
        step(1'b0, 1'b1, 1'b0, 8'h62, "t6_w1");
        step(1'b0, 1'b1, 1'b0, 8'h63, "t6_w2");
        step(1'b1, 1'b0, 1'b0, 8'h00, "t6_rst");
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_dout0", 32'(dout), 32'h00);
        step(1'b0, 1'b1, 1'b0, 8'h77, "t6_w77");
        chk("t6_dout77", 32'(dout), 32'h77);
        chk("t6_last", 32'(last), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
